ddr_wr_burst_master: RTL and testbench
======================================

// Module: ddr_wr_burst_master
// PURPOSE
//  Downstream of a write-channel address controller (wr0..wr3): takes one frame-slice command
//  (start address + burst count), drains pixel data from an FWFT FIFO, issues AXI4 INCR write
//  bursts to the DDR controller. Pulses wr_ddr_done when the last write response returns,
//  which lets the address controller advance to the next slice.
// PARAMETERS
//  ADDR_WIDTH    30   AXI byte-address width
//  WR_NUM_WIDTH  16   width of burst-count field
//  DATA_WIDTH    256  AXI/FIFO data width (bits)
//  BURST_LEN     8    beats per burst; awlen = BURST_LEN-1
//  FIFO_CNT_W    10   width of FIFO read-count
// PORTS
//  clk                  in   1             single clock (DDR UI clock)
//  rst                  in   1             asynchronous reset, active-high
//  init_calib_complete  in   1             DDR ready; no AW issued while low
//  wr_addr_valid        in   1             1-cycle command strobe
//  wr_ddr_addr          in   ADDR_WIDTH    start byte address, sampled with strobe
//  wr_ddr_num           in   WR_NUM_WIDTH  number of bursts, sampled with strobe
//  wr_ddr_done          out  1             1-cycle pulse, command complete
//  busy                 out  1             command active
//  cmd_overflow         out  1             sticky: strobe lost (pending slot full)
//  fifo_rd_cnt          in   FIFO_CNT_W    beats available in FIFO
//  fifo_rd_en           out  1             FWFT pop
//  fifo_rd_data         in   DATA_WIDTH    FWFT head data
//  axi_awaddr/awlen/awvalid out ADDR_WIDTH/8/1; axi_awready in 1
//  axi_wdata/wstrb/wlast/wvalid out DATA_WIDTH/DATA_WIDTH/8/1/1; axi_wready in 1
//  axi_bvalid in 1; axi_bready out 1
// BEHAVIOUR
//  Reset: every output 0, FSM IDLE, counters 0, pending slot empty, cmd_overflow cleared.
//  Command capture: strobe in IDLE with empty slot -> load active regs directly. Strobe while
//   busy -> one-deep pending slot; strobe with slot full -> dropped, cmd_overflow<=1.
//  wr_ddr_num==0: no AXI traffic; wr_ddr_done pulses 1 cycle after strobe.
//  FSM: IDLE -> WAIT_DATA (active cmd) -> AW -> W -> B -> (bursts left ? WAIT_DATA : DONE) -> IDLE.
//   WAIT_DATA: leave when init_calib_complete & fifo_rd_cnt >= BURST_LEN (no underrun inside W).
//   AW: awvalid=1 held, awaddr/awlen stable until awready; then W.
//   W: wvalid=1; beat on wvalid&wready; fifo_rd_en = wvalid&wready (comb.);
//      wdata = fifo_rd_data (comb.); wstrb all-ones; wlast on beat BURST_LEN-1.
//   B: bready=1; on bvalid -> addr += BURST_LEN*DATA_WIDTH/8, remaining -= 1.
//   DONE: wr_ddr_done=1 one cycle; if pending slot full, load it and go WAIT_DATA (no IDLE gap).
//  Latency: strobe -> awvalid = 2 cycles min (capture, WAIT_DATA check).
//  Only one burst outstanding; bresp ignored.
//  Address: ADDR_WIDTH-bit modulo wrap, no carry out; remaining count WR_NUM_WIDTH bits.
//  busy = FSM != IDLE.
//  awready/wready deasserted mid-burst: hold all outputs, no FIFO pop.
//  init_calib_complete drop mid-burst: current burst completes; next WAIT_DATA stalls.
//  Async rst mid-burst: immediate return to reset state; DDR-side recovery is system reset's job.
// STRUCTURE
//  Shared package ddr_pkg: FSM state encoding, AXI_BURST_INCR, BYTES_PER_BURST function.
//  One sub-module: ddr_wr_cmd_slot (active + one-deep pending command register, overflow flag).
//  Rest is a single FSM plus beat/burst counters.
// TESTING
//  1 strobe addr=0x0000_0000 num=3, FIFO full, ready always 1 -> awaddr 0x000,0x100,0x200,
//    awlen=7, 24 W beats, wlast on beats 8/16/24, one done pulse after third bvalid.
//  2 fifo_rd_cnt=7 for 20 cycles, then 8 -> no awvalid until count reaches 8; no pop while waiting.
//  3 random awready/wready/bvalid back-pressure, num=4 -> data order matches FIFO order,
//    32 pops total, no beat lost/duplicated.
//  4 strobe A num=2, strobe B during A's W, strobe C while B pending -> A done then B starts
//    next cycle; C dropped, cmd_overflow=1.
//  5 num=0 -> no AXI activity, done 1 cycle after strobe; addr=0x3FFF_FF00 num=2 -> second
//    awaddr 0x0000_0000.
//  6 rst asserted mid-W beat 4 -> all outputs 0 same cycle, FSM IDLE, next strobe runs cleanly.

Source files
------------

// File: rtl/ddr_pkg.sv
// Shared definitions for the DDR write-burst master: FSM state encoding,
// AXI burst type and the per-burst byte stride helper.
package ddr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_DATA = 3'd1,
        ST_AW        = 3'd2,
        ST_W         = 3'd3,
        ST_B         = 3'd4,
        ST_DONE      = 3'd5
    } wr_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // Bytes covered by one burst: beats per burst times bytes per beat.
    function automatic int bytes_per_burst(input int burst_len, input int data_width);
        return burst_len * (data_width / 32'sd8);
    endfunction

endpackage

// File: rtl/ddr_wr_cmd_slot.sv
// Command holding registers for the write-burst master.
// Keeps the active command (address and bursts remaining, advanced after
// every write response) and a one-deep pending slot for a command that
// arrives while the master is busy. A strobe that finds the slot full is
// dropped and latches a sticky overflow flag.
module ddr_wr_cmd_slot
    import ddr_pkg::*;
#(
    parameter int ADDR_WIDTH   = 30,
    parameter int WR_NUM_WIDTH = 16,
    parameter int DATA_WIDTH   = 256,
    parameter int BURST_LEN    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [WR_NUM_WIDTH-1:0] cmd_num,
    input  logic                    fsm_idle,
    input  logic                    pend_pop,
    input  logic                    burst_done,
    output logic [ADDR_WIDTH-1:0]   act_addr,
    output logic [WR_NUM_WIDTH-1:0] act_num,
    output logic                    pend_full,
    output logic [WR_NUM_WIDTH-1:0] pend_num,
    output logic                    overflow
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP =
        ADDR_WIDTH'(bytes_per_burst(BURST_LEN, DATA_WIDTH));

    logic [ADDR_WIDTH-1:0]   act_addr_q,  act_addr_d;
    logic [WR_NUM_WIDTH-1:0] act_num_q,   act_num_d;
    logic [ADDR_WIDTH-1:0]   pend_addr_q, pend_addr_d;
    logic [WR_NUM_WIDTH-1:0] pend_num_q,  pend_num_d;
    logic                    pend_full_q, pend_full_d;
    logic                    overflow_q,  overflow_d;
    logic                    take_direct_s;
    logic                    take_pend_s;
    logic                    drop_s;

    // Classify an incoming strobe: straight into the active regs, into the pending slot, or lost.
    always_comb begin
        take_direct_s = cmd_valid & fsm_idle & ~pend_full_q;
        take_pend_s   = cmd_valid & ~take_direct_s & (~pend_full_q | pend_pop);
        drop_s        = cmd_valid & ~take_direct_s & ~take_pend_s;
    end

    // Next values of the active command, pending slot and overflow flag.
    always_comb begin
        act_addr_d  = act_addr_q;
        act_num_d   = act_num_q;
        pend_addr_d = pend_addr_q;
        pend_num_d  = pend_num_q;
        pend_full_d = pend_full_q;
        overflow_d  = overflow_q | drop_s;

        if (take_direct_s) begin
            act_addr_d = cmd_addr;
            act_num_d  = cmd_num;
        end else if (pend_pop) begin
            act_addr_d = pend_addr_q;
            act_num_d  = pend_num_q;
        end else if (burst_done) begin
            // Address wraps modulo 2^ADDR_WIDTH with no carry out.
            act_addr_d = act_addr_q + ADDR_STEP;
            act_num_d  = act_num_q - WR_NUM_WIDTH'(1);
        end else begin
            act_addr_d = act_addr_q;
            act_num_d  = act_num_q;
        end

        if (take_pend_s) begin
            pend_addr_d = cmd_addr;
            pend_num_d  = cmd_num;
            pend_full_d = 1'b1;
        end else if (pend_pop) begin
            pend_full_d = 1'b0;
        end else begin
            pend_full_d = pend_full_q;
        end
    end

    // Command registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_addr_q  <= {ADDR_WIDTH{1'b0}};
            act_num_q   <= {WR_NUM_WIDTH{1'b0}};
            pend_addr_q <= {ADDR_WIDTH{1'b0}};
            pend_num_q  <= {WR_NUM_WIDTH{1'b0}};
            pend_full_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            act_addr_q  <= act_addr_d;
            act_num_q   <= act_num_d;
            pend_addr_q <= pend_addr_d;
            pend_num_q  <= pend_num_d;
            pend_full_q <= pend_full_d;
            overflow_q  <= overflow_d;
        end
    end

    assign act_addr  = act_addr_q;
    assign act_num   = act_num_q;
    assign pend_full = pend_full_q;
    assign pend_num  = pend_num_q;
    assign overflow  = overflow_q;

endmodule

// File: rtl/ddr_wr_burst_master.sv
// DDR write-burst master: turns one frame-slice command (start address,
// burst count) into a sequence of AXI4 INCR write bursts fed from an FWFT
// FIFO, with a single burst outstanding at a time. A burst is only started
// once the FIFO already holds a full burst, so W never underruns. AXI
// valids and the done/busy flags decode directly from the state register;
// write data and the FIFO pop follow the FIFO head and wready within the
// cycle so a beat moves on every accepted handshake.
module ddr_wr_burst_master
    import ddr_pkg::*;
#(
    parameter int ADDR_WIDTH   = 30,
    parameter int WR_NUM_WIDTH = 16,
    parameter int DATA_WIDTH   = 256,
    parameter int BURST_LEN    = 8,
    parameter int FIFO_CNT_W   = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      init_calib_complete,
    input  logic                      wr_addr_valid,
    input  logic [ADDR_WIDTH-1:0]     wr_ddr_addr,
    input  logic [WR_NUM_WIDTH-1:0]   wr_ddr_num,
    output logic                      wr_ddr_done,
    output logic                      busy,
    output logic                      cmd_overflow,
    input  logic [FIFO_CNT_W-1:0]     fifo_rd_cnt,
    output logic                      fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]     fifo_rd_data,
    output logic [ADDR_WIDTH-1:0]     axi_awaddr,
    output logic [7:0]                axi_awlen,
    output logic                      axi_awvalid,
    input  logic                      axi_awready,
    output logic [DATA_WIDTH-1:0]     axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   axi_wstrb,
    output logic                      axi_wlast,
    output logic                      axi_wvalid,
    input  logic                      axi_wready,
    input  logic                      axi_bvalid,
    output logic                      axi_bready
);

    localparam int                BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [7:0]        AWLEN_VAL = 8'(BURST_LEN - 1);

    wr_state_e               state_q, state_d;
    logic [BEAT_W-1:0]       beat_q,  beat_d;
    logic                    fsm_idle_s;
    logic                    pend_pop_s;
    logic                    burst_done_s;
    logic                    data_ready_s;
    logic [ADDR_WIDTH-1:0]   act_addr_s;
    logic [WR_NUM_WIDTH-1:0] act_num_s;
    logic                    pend_full_s;
    logic [WR_NUM_WIDTH-1:0] pend_num_s;
    logic                    overflow_s;

    ddr_wr_cmd_slot #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .WR_NUM_WIDTH (WR_NUM_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH),
        .BURST_LEN    (BURST_LEN)
    ) u_cmd_slot (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (wr_addr_valid),
        .cmd_addr   (wr_ddr_addr),
        .cmd_num    (wr_ddr_num),
        .fsm_idle   (fsm_idle_s),
        .pend_pop   (pend_pop_s),
        .burst_done (burst_done_s),
        .act_addr   (act_addr_s),
        .act_num    (act_num_s),
        .pend_full  (pend_full_s),
        .pend_num   (pend_num_s),
        .overflow   (overflow_s)
    );

    assign fsm_idle_s   = (state_q == ST_IDLE);
    assign data_ready_s = init_calib_complete & (fifo_rd_cnt >= FIFO_CNT_W'(BURST_LEN));

    // Next-state logic, beat counter and slot control strobes.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        pend_pop_s   = 1'b0;
        burst_done_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pend_full_s) begin
                    pend_pop_s = 1'b1;
                    state_d    = (pend_num_s == {WR_NUM_WIDTH{1'b0}}) ? ST_DONE : ST_WAIT_DATA;
                end else if (wr_addr_valid) begin
                    // A zero-burst command completes without touching AXI.
                    state_d = (wr_ddr_num == {WR_NUM_WIDTH{1'b0}}) ? ST_DONE : ST_WAIT_DATA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_DATA: begin
                if (data_ready_s) begin
                    state_d = ST_AW;
                end else begin
                    state_d = ST_WAIT_DATA;
                end
            end
            ST_AW: begin
                if (axi_awready) begin
                    state_d = ST_W;
                end else begin
                    state_d = ST_AW;
                end
            end
            ST_W: begin
                if (axi_wready) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = {BEAT_W{1'b0}};
                        state_d = ST_B;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end else begin
                    beat_d = beat_q;
                end
            end
            ST_B: begin
                if (axi_bvalid) begin
                    burst_done_s = 1'b1;
                    state_d      = (act_num_s > WR_NUM_WIDTH'(1)) ? ST_WAIT_DATA : ST_DONE;
                end else begin
                    state_d = ST_B;
                end
            end
            ST_DONE: begin
                // Chain straight into a pending command without an IDLE gap.
                if (pend_full_s) begin
                    pend_pop_s = 1'b1;
                    state_d    = (pend_num_s == {WR_NUM_WIDTH{1'b0}}) ? ST_DONE : ST_WAIT_DATA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                beat_d  = {BEAT_W{1'b0}};
            end
        endcase
    end

    // State and beat counter registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            beat_q  <= {BEAT_W{1'b0}};
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // Output decode; every data-path output is forced to zero outside its phase.
    always_comb begin
        axi_awvalid  = (state_q == ST_AW);
        axi_awaddr   = axi_awvalid ? act_addr_s : {ADDR_WIDTH{1'b0}};
        axi_awlen    = axi_awvalid ? AWLEN_VAL  : 8'd0;
        axi_wvalid   = (state_q == ST_W);
        axi_wdata    = axi_wvalid ? fifo_rd_data : {DATA_WIDTH{1'b0}};
        axi_wstrb    = axi_wvalid ? {(DATA_WIDTH/8){1'b1}} : {(DATA_WIDTH/8){1'b0}};
        axi_wlast    = axi_wvalid & (beat_q == LAST_BEAT);
        fifo_rd_en   = axi_wvalid & axi_wready;
        axi_bready   = (state_q == ST_B);
        wr_ddr_done  = (state_q == ST_DONE);
        busy         = (state_q != ST_IDLE);
        cmd_overflow = overflow_s;
    end

endmodule

// File: tb/tb_ddr_wr_burst_master.sv
// Self-checking bench for ddr_wr_burst_master. Provides an FWFT FIFO and
// an AXI write slave, records every handshake, and compares the recorded
// traffic against a command-level model (burst addresses from start
// address plus multiples of 0x100, data in FIFO push order).
module tb_ddr_wr_burst_master;

    localparam int AW_W = 30;
    localparam int NW   = 16;
    localparam int DW   = 256;
    localparam int CW   = 10;
    localparam logic [AW_W-1:0] STEP = 30'h100;   // 8 beats x 32 bytes

    typedef logic [DW-1:0] data_t;
    typedef struct {
        logic [AW_W-1:0] addr;
        logic [NW-1:0]   num;
        logic [AW_W-1:0] exp_last_aw;
        int              exp_lat;
    } vec_t;

    logic              clk;
    logic              rst;
    logic              init_calib_complete;
    logic              wr_addr_valid;
    logic [AW_W-1:0]   wr_ddr_addr;
    logic [NW-1:0]     wr_ddr_num;
    logic              wr_ddr_done;
    logic              busy;
    logic              cmd_overflow;
    logic [CW-1:0]     fifo_rd_cnt;
    logic              fifo_rd_en;
    logic [DW-1:0]     fifo_rd_data;
    logic [AW_W-1:0]   axi_awaddr;
    logic [7:0]        axi_awlen;
    logic              axi_awvalid;
    logic              axi_awready;
    logic [DW-1:0]     axi_wdata;
    logic [DW/8-1:0]   axi_wstrb;
    logic              axi_wlast;
    logic              axi_wvalid;
    logic              axi_wready;
    logic              axi_bvalid;
    logic              axi_bready;

    data_t           fifo_q[$];
    data_t           exp_data[$];
    data_t           got_data[$];
    logic            got_last[$];
    logic [AW_W-1:0] exp_aw[$];
    logic [AW_W-1:0] got_aw[$];
    logic [7:0]      got_len[$];
    int              aw_cyc[$];
    int              done_cyc[$];
    int              cyc, n_pass, n_total, pops, b_owed, cnt_limit, exp_done;
    bit              rand_bp;

    ddr_wr_burst_master #(
        .ADDR_WIDTH(AW_W), .WR_NUM_WIDTH(NW), .DATA_WIDTH(DW), .BURST_LEN(8), .FIFO_CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .init_calib_complete(init_calib_complete),
        .wr_addr_valid(wr_addr_valid), .wr_ddr_addr(wr_ddr_addr), .wr_ddr_num(wr_ddr_num),
        .wr_ddr_done(wr_ddr_done), .busy(busy), .cmd_overflow(cmd_overflow),
        .fifo_rd_cnt(fifo_rd_cnt), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
        .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awvalid(axi_awvalid),
        .axi_awready(axi_awready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    function automatic logic any_out();
        return |{axi_awvalid, axi_awaddr, axi_awlen, axi_wvalid, axi_wdata, axi_wstrb,
                 axi_wlast, axi_bready, fifo_rd_en, wr_ddr_done, busy, cmd_overflow};
    endfunction

    // Slave/FIFO drive, applied just after a rising edge.
    task automatic drive();
        axi_awready  = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
        axi_wready   = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
        axi_bvalid   = (b_owed > 0) && (rand_bp ? ($urandom_range(0, 1) == 1) : 1'b1);
        fifo_rd_cnt  = (fifo_q.size() < cnt_limit) ? CW'(fifo_q.size()) : CW'(cnt_limit);
        fifo_rd_data = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    endtask

    // One clock: sample handshakes on the falling edge, update slave state after the rising edge.
    task automatic tick();
        bit pop_s, last_s, b_hs;
        @(negedge clk);
        pop_s  = fifo_rd_en;
        b_hs   = axi_bvalid && axi_bready;
        last_s = 1'b0;
        if (axi_awvalid && axi_awready) begin
            got_aw.push_back(axi_awaddr);
            got_len.push_back(axi_awlen);
            aw_cyc.push_back(cyc);
        end
        if (axi_wvalid && axi_wready) begin
            got_data.push_back(axi_wdata);
            got_last.push_back(axi_wlast);
            last_s = axi_wlast;
        end
        if (fifo_rd_en) pops++;
        if (wr_ddr_done) done_cyc.push_back(cyc);
        @(posedge clk);
        #1;
        cyc++;
        if (pop_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (last_s) b_owed++;
        if (b_hs) b_owed--;
        drive();
    endtask

    task automatic clear_caps();
        exp_data.delete(); got_data.delete(); got_last.delete();
        exp_aw.delete(); got_aw.delete(); got_len.delete();
        aw_cyc.delete(); done_cyc.delete();
        pops = 0; exp_done = 0;
    endtask

    task automatic push_beats(input int n);
        data_t d;
        for (int i = 0; i < n; i++) begin
            d = {8{$urandom()}};
            fifo_q.push_back(d);
            exp_data.push_back(d);
        end
        drive();
    endtask

    // Command-level model: one AW per burst at start + i*0x100, one done per command.
    task automatic model_cmd(input logic [AW_W-1:0] a, input int n);
        for (int i = 0; i < n; i++) exp_aw.push_back(a + AW_W'(i) * STEP);
        exp_done++;
    endtask

    task automatic strobe(input logic [AW_W-1:0] a, input logic [NW-1:0] n);
        wr_addr_valid = 1'b1; wr_ddr_addr = a; wr_ddr_num = n;
        tick();
        wr_addr_valid = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget);
        int k = 0;
        while (done_cyc.size() < n && k < budget) begin tick(); k++; end
        if (done_cyc.size() < n) chk("done_timeout", done_cyc.size(), n);
        repeat (8) tick();
    endtask

    task automatic verify(input string tag);
        int am = 0, lm = 0, dm = 0, wm = 0;
        chk({tag, "_aw_count"}, got_aw.size(), exp_aw.size());
        for (int i = 0; i < got_aw.size() && i < exp_aw.size(); i++) begin
            if (got_aw[i] !== exp_aw[i]) am++;
            if (got_len[i] !== 8'd7) lm++;
        end
        chk({tag, "_awaddr_mismatches"}, am, 0);
        chk({tag, "_awlen_mismatches"}, lm, 0);
        chk({tag, "_beat_count"}, got_data.size(), exp_data.size());
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
            if (got_data[i] !== exp_data[i]) dm++;
            if (got_last[i] !== ((i % 8) == 7)) wm++;
        end
        chk({tag, "_wdata_mismatches"}, dm, 0);
        chk({tag, "_wlast_mismatches"}, wm, 0);
        chk({tag, "_pop_count"}, pops, exp_data.size());
        chk({tag, "_done_count"}, done_cyc.size(), exp_done);
    endtask

    initial begin
        vec_t            vecs[4];
        int              s, k, n;
        logic [AW_W-1:0] a;

        vecs[0] = '{30'h0000_0000, 16'd3, 30'h0000_0200, 34};
        vecs[1] = '{30'h3FFF_FF00, 16'd2, 30'h0000_0000, 23};
        vecs[2] = '{30'h0012_3400, 16'd0, 30'h0000_0000, 1};
        vecs[3] = '{30'h0000_0040, 16'd1, 30'h0000_0040, 12};

        n_pass = 0; n_total = 0; cyc = 0; b_owed = 0; cnt_limit = 1023; rand_bp = 1'b0;
        rst = 1'b1; init_calib_complete = 1'b1;
        wr_addr_valid = 1'b0; wr_ddr_addr = '0; wr_ddr_num = '0;
        clear_caps();
        drive();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs_zero", any_out(), 1'b0);
        chk("reset_busy", busy, 1'b0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;

        // Table-driven commands with ready always high.
        for (int v = 0; v < 4; v++) begin
            clear_caps();
            push_beats(int'(vecs[v].num) * 8);
            model_cmd(vecs[v].addr, int'(vecs[v].num));
            s = cyc;
            strobe(vecs[v].addr, vecs[v].num);
            wait_done(1, 300);
            verify($sformatf("vec%0d", v));
            chk($sformatf("vec%0d_done_latency", v),
                (done_cyc.size() > 0) ? done_cyc[0] - s : -1, vecs[v].exp_lat);
            if (vecs[v].num != 16'd0) begin
                chk($sformatf("vec%0d_aw_latency", v), (aw_cyc.size() > 0) ? aw_cyc[0] - s : -1, 2);
                chk($sformatf("vec%0d_last_awaddr", v),
                    (got_aw.size() > 0) ? got_aw[got_aw.size() - 1] : 30'h3FFF_FFFF,
                    vecs[v].exp_last_aw);
            end
        end

        // Random back-pressure on AW/W/B.
        for (int r = 0; r < 3; r++) begin
            clear_caps();
            rand_bp = 1'b1;
            n = (r == 0) ? 4 : int'($urandom_range(1, 4));
            a = AW_W'($urandom());
            push_beats(n * 8);
            model_cmd(a, n);
            strobe(a, NW'(n));
            wait_done(1, 2000);
            verify($sformatf("rand%0d", r));
        end
        rand_bp = 1'b0;
        drive();

        // FIFO holds one beat short of a burst, then calibration low.
        clear_caps();
        cnt_limit = 7;
        push_beats(8);
        model_cmd(30'h0000_0500, 1);
        strobe(30'h0000_0500, 16'd1);
        repeat (20) tick();
        chk("cnt7_no_aw", got_aw.size(), 0);
        chk("cnt7_no_pop", pops, 0);
        chk("cnt7_awvalid_low", axi_awvalid, 1'b0);
        init_calib_complete = 1'b0;
        cnt_limit = 1023;
        drive();
        repeat (10) tick();
        chk("calib_low_no_aw", got_aw.size(), 0);
        init_calib_complete = 1'b1;
        s = cyc;
        wait_done(1, 300);
        verify("wait_data");
        chk("wait_data_aw_after_ready", (aw_cyc.size() > 0) ? aw_cyc[0] - s : -1, 1);

        // A runs, B queued during A's W phase, C dropped while B pending.
        clear_caps();
        push_beats(24);
        model_cmd(30'h0000_1000, 2);
        model_cmd(30'h0000_2000, 1);
        strobe(30'h0000_1000, 16'd2);
        k = 0;
        while (got_data.size() == 0 && k < 50) begin tick(); k++; end
        strobe(30'h0000_2000, 16'd1);
        chk("ovf_before_c", cmd_overflow, 1'b0);
        tick();
        strobe(30'h0000_3000, 16'd1);
        chk("ovf_after_c", cmd_overflow, 1'b1);
        wait_done(2, 400);
        verify("pend");
        chk("pend_b_start_gap",
            (aw_cyc.size() > 2 && done_cyc.size() > 0) ? aw_cyc[2] - done_cyc[0] : -1, 2);

        // Asynchronous reset in the middle of a W burst.
        clear_caps();
        push_beats(8);
        strobe(30'h0000_0800, 16'd1);
        k = 0;
        while (got_data.size() < 4 && k < 50) begin tick(); k++; end
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_outputs_zero", any_out(), 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_overflow_cleared", cmd_overflow, 1'b0);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        fifo_q.delete();
        b_owed = 0;
        clear_caps();
        push_beats(8);
        model_cmd(30'h0000_0800, 1);
        s = cyc;
        strobe(30'h0000_0800, 16'd1);
        wait_done(1, 300);
        verify("post_rst");
        chk("post_rst_done_latency", (done_cyc.size() > 0) ? done_cyc[0] - s : -1, 12);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
